// File: rtl/line_packer.sv
// rtl/line_packer.sv - buffers a bursty pixel stream and emits whole lines aligned to a free-running column counter
module line_packer #(
   parameter int                   TAG_WIDTH    = 2,
   parameter logic [TAG_WIDTH-1:0] INVALID_TAG  = 2'd0,
   parameter logic [TAG_WIDTH-1:0] DATA_TAG0    = 2'd1,
   parameter logic [TAG_WIDTH-1:0] DATA_TAG1    = 2'd2,
   parameter logic [TAG_WIDTH-1:0] DATA_END_TAG = 2'd3,
   parameter int                   DATA_WIDTH   = 8 + TAG_WIDTH,
   parameter int                   FIFO_DEPTH   = 2048
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reflesh,
   input  logic [31:0]           image_width,
   input  logic [31:0]           image_height,
   input  logic [7:0]            pix_in,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LINE, S_DONE} state_t;

   state_t               state, state_next;
   logic [7:0]           mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count, count_next;
   logic [9:0]           col, width_m1;
   logic [10:0]          width_full;
   logic [15:0]          row, row_next, height;
   logic                 push, pop, col_wrap, last_row;
   logic [TAG_WIDTH-1:0] tag;
   logic [7:0]           head;
   logic                 unused_bits;

   // Only the low bits of the geometry inputs are meaningful.
   assign unused_bits = ^{image_width[31:10], image_height[31:16]};

   // A width field of zero encodes 1024, so the wrap compare is 1023 and the fill threshold is 1024.
   assign width_m1   = image_width[9:0] - 10'd1;
   assign width_full = {image_width[9:0] == 10'd0, image_width[9:0]};
   assign height     = image_height[15:0];

   assign col_wrap   = (col == width_m1);
   assign pix_ready  = (count != COUNT_FULL);
   assign push       = pix_valid & pix_ready;
   assign pop        = (state == S_LINE);
   assign count_next = count + CW'(push) - CW'(pop);
   assign row_next   = row + 16'(pop & col_wrap);
   assign last_row   = (row == height - 16'd1);
   assign head       = mem[rd_ptr];
   assign frame_done = (state == S_DONE);

   // Pixel storage; entries beyond the pointers are don't-care, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= pix_in;
      end
   end

   // Column mirror, row counter and FIFO bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col    <= '0;
         row    <= '0;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (reflesh) begin
         col    <= '0;
         row    <= '0;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         col    <= col_wrap ? 10'd0 : col + 10'd1;
         row    <= row_next;
         count  <= count_next;
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
      end
   end

   // Slot state register; changes only at a column wrap or on restart.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else if (reflesh) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Slot decision at the wrap: frame finished first, then whole line buffered, else filler.
   always_comb begin
      state_next = state;
      if (col_wrap && state != S_DONE) begin
         if (row_next == height) begin
            state_next = S_DONE;
         end else if (count_next >= CW'(width_full)) begin
            state_next = S_LINE;
         end else begin
            state_next = S_IDLE;
         end
      end
   end

   // Tag for the pixel popped this cycle: row parity, or end marker on the frame's final pixel.
   always_comb begin
      tag = row[0] ? DATA_TAG1 : DATA_TAG0;
      if (last_row && col_wrap) begin
         tag = DATA_END_TAG;
      end
   end

   // Output word, reloaded every edge; filler whenever no line is running.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out <= '0;
      end else if (reflesh) begin
         data_out <= '0;
      end else if (state == S_LINE) begin
         data_out <= {tag, head};
      end else begin
         data_out <= {INVALID_TAG, 8'h00};
      end
   end

endmodule

// File: tb/tb_line_packer.sv
// tb/tb_line_packer.sv - directed self-checking bench for line_packer
module tb_line_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        reflesh;
   logic [31:0] image_width;
   logic [31:0] image_height;
   logic [7:0]  pix_in;
   logic        pix_valid;
   logic        pix_ready;
   logic [9:0]  data_out;
   logic        frame_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   line_packer dut (
      .clk          (clk),
      .rst          (rst),
      .reflesh      (reflesh),
      .image_width  (image_width),
      .image_height (image_height),
      .pix_in       (pix_in),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .data_out     (data_out),
      .frame_done   (frame_done)
   );

   task automatic step(input logic v, input logic [7:0] p);
      pix_valid = v;
      pix_in    = p;
      @(negedge clk);
   endtask

   task automatic restart(input int w, input int h);
      reflesh      = 1'b1;
      pix_valid    = 1'b0;
      image_width  = w;
      image_height = h;
      @(negedge clk);
      reflesh = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; reflesh = 1'b0; pix_valid = 1'b0; pix_in = 8'h00;
      image_width = 4; image_height = 2;
      @(negedge clk);
      @(negedge clk);
      total++; if (data_out !== 10'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", data_out); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", frame_done); end
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", pix_ready); end
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [9:0] exp;
      restart(4, 2);
      for (int e = 1; e <= 16; e++) begin
         step(e <= 8, 8'(8'h10 + e - 1));
         if (e >= 5 && e <= 8)       exp = {2'd1, 8'(8'h10 + e - 5)};
         else if (e >= 9 && e <= 11) exp = {2'd2, 8'(8'h14 + e - 9)};
         else if (e == 12)           exp = {2'd3, 8'h17};
         else                        exp = 10'h000;
         total++; if (data_out !== exp) begin bad++; $display("FAIL basic_word e=%0d got=%h exp=%h", e, data_out, exp); end
         if (e == 11 || e == 16) begin
            total++; if (frame_done !== (e == 16)) begin bad++; $display("FAIL basic_done e=%0d got=%b", e, frame_done); end
         end
      end
   endtask

   task automatic test_sparse();
      logic [9:0] exp;
      restart(8, 3);
      for (int e = 1; e <= 136; e++) begin
         step((e % 5 == 1) && e <= 116, 8'(8'h40 + (e - 1) / 5));
         if (e >= 41 && e <= 48)        exp = {2'd1, 8'(8'h40 + e - 41)};
         else if (e >= 81 && e <= 88)   exp = {2'd2, 8'(8'h48 + e - 81)};
         else if (e >= 121 && e <= 127) exp = {2'd1, 8'(8'h50 + e - 121)};
         else if (e == 128)             exp = {2'd3, 8'h57};
         else                           exp = 10'h000;
         total++; if (data_out !== exp) begin bad++; $display("FAIL sparse_word e=%0d got=%h exp=%h", e, data_out, exp); end
      end
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL sparse_done got=%b exp=1", frame_done); end
   endtask

   task automatic test_backpressure();
      int   acc = 0;
      logic dropped = 1'b0;
      logic reraised = 1'b0;
      int   data_err = 0;
      restart(4, 0);
      for (int e = 1; e <= 2060; e++) begin
         if (dropped && pix_ready) reraised = 1'b1;
         if (!pix_ready) dropped = 1'b1;
         if (pix_ready) acc++;
         step(1'b1, 8'(e));
         if (data_out !== 10'h000) data_err++;
      end
      pix_valid = 1'b0;
      total++; if (acc != 2048) begin bad++; $display("FAIL bp_accepts got=%0d exp=2048", acc); end
      total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", pix_ready); end
      total++; if (reraised !== 1'b0) begin bad++; $display("FAIL bp_ready_rose got=%b exp=0", reraised); end
      total++; if (data_err != 0) begin bad++; $display("FAIL bp_data nonzero_words=%0d exp=0", data_err); end
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", frame_done); end
   endtask

   task automatic test_reflesh_mid_line();
      logic [9:0] exp;
      restart(16, 4);
      for (int e = 1; e <= 39; e++) begin
         step(1'b1, 8'(8'h80 + e - 1));
         if (e >= 17 && e <= 32)      exp = {2'd1, 8'(8'h80 + e - 17)};
         else if (e >= 33)            exp = {2'd2, 8'(8'h90 + e - 33)};
         else                         exp = 10'h000;
         total++; if (data_out !== exp) begin bad++; $display("FAIL rf_pre e=%0d got=%h exp=%h", e, data_out, exp); end
      end
      reflesh = 1'b1;
      step(1'b1, 8'hEE);
      reflesh = 1'b0;
      total++; if (data_out !== 10'h000) begin bad++; $display("FAIL rf_data got=%h exp=000", data_out); end
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL rf_ready got=%b exp=1", pix_ready); end
      for (int e = 1; e <= 84; e++) begin
         step(e <= 64, 8'(8'hC0 + e - 1));
         if (e >= 17 && e <= 32)      exp = {2'd1, 8'(8'hC0 + e - 17)};
         else if (e >= 33 && e <= 48) exp = {2'd2, 8'(8'hD0 + e - 33)};
         else if (e >= 49 && e <= 64) exp = {2'd1, 8'(8'hE0 + e - 49)};
         else if (e >= 65 && e <= 79) exp = {2'd2, 8'(8'hF0 + e - 65)};
         else if (e == 80)            exp = {2'd3, 8'hFF};
         else                         exp = 10'h000;
         total++; if (data_out !== exp) begin bad++; $display("FAIL rf_post e=%0d got=%h exp=%h", e, data_out, exp); end
      end
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL rf_done got=%b exp=1", frame_done); end
   endtask

   task automatic test_async_reset();
      logic [9:0] exp;
      restart(4, 2);
      for (int e = 1; e <= 6; e++) step(1'b1, 8'(8'h20 + e - 1));
      total++; if (data_out !== {2'd1, 8'h21}) begin bad++; $display("FAIL ar_pre got=%h exp=121", data_out); end
      #2;
      rst = 1'b0;
      pix_valid = 1'b0;
      #1;
      total++; if (data_out !== 10'h000) begin bad++; $display("FAIL ar_data got=%h exp=000", data_out); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL ar_done got=%b exp=0", frame_done); end
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b exp=1", pix_ready); end
      @(negedge clk);
      total++; if (data_out !== 10'h000) begin bad++; $display("FAIL ar_hold got=%h exp=000", data_out); end
      rst = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step(e <= 4, 8'(8'h30 + e - 1));
         exp = (e >= 5) ? {2'd1, 8'(8'h30 + e - 5)} : 10'h000;
         total++; if (data_out !== exp) begin bad++; $display("FAIL ar_post e=%0d got=%h exp=%h", e, data_out, exp); end
      end
   endtask

   task automatic test_max_width();
      logic [9:0] exp;
      restart(1024, 2);
      for (int e = 1; e <= 3076; e++) begin
         step(e <= 2048, 8'(e - 1));
         if (e >= 1025 && e <= 2048)      exp = {2'd1, 8'(e - 1025)};
         else if (e >= 2049 && e <= 3071) exp = {2'd2, 8'(e - 1025)};
         else if (e == 3072)              exp = {2'd3, 8'hFF};
         else                             exp = 10'h000;
         total++; if (data_out !== exp) begin bad++; $display("FAIL maxw_word e=%0d got=%h exp=%h", e, data_out, exp); end
      end
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL maxw_done got=%b exp=1", frame_done); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sparse();
      test_backpressure();
      test_reflesh_mid_line();
      test_async_reset();
      test_max_width();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
